game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_if.sv | 43 ++++
 rtl/game_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/game_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_ctrl_if
// Signal bundle between the game controller and the rest of the game.
//   Inputs to the controller (driven by the environment):
//     frame_tick                          one-cycle pulse per video frame
//     key_start/key_left/key_right/key_jump  keyboard levels, synchronous to clk
//     hit                                 one-cycle pulse: player hit by a barrel
//     win                                 one-cycle pulse: player reached the goal
//   Outputs from the controller:
//     start_game                          enables the player movement block
//     left/right/jump                     gated movement commands
//     player_rst                          one-cycle pulse: player back to start
//     lives[1:0]                          remaining lives
//     game_state[2:0]                     MENU=0 PLAY=1 HIT=2 WIN=3 OVER=4
// The master modport is the environment side, the slave modport is game_ctrl.
// ---------------------------------------------------------------------------
interface game_ctrl_if;
  logic       frame_tick;
  logic       key_start;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic       hit;
  logic       win;

  logic       start_game;
  logic       left;
  logic       right;
  logic       jump;
  logic       player_rst;
  logic [1:0] lives;
  logic [2:0] game_state;

  modport master (
    output frame_tick, key_start, key_left, key_right, key_jump, hit, win,
    input  start_game, left, right, jump, player_rst, lives, game_state
  );

  modport slave (
    input  frame_tick, key_start, key_left, key_right, key_jump, hit, win,
    output start_game, left, right, jump, player_rst, lives, game_state
  );
endinterface

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
// Top-level game flow controller: menu, play, hit freeze, win and game-over
// screens, life counting and gating of the player movement commands.
//
// Parameters:
//   LIVES_INIT        lives loaded when a game starts (1..3)
//   HIT_FREEZE_FRAMES frame ticks the game stays frozen after a hit
//   END_HOLD_FRAMES   frame ticks the WIN / OVER screen is held
// Ports:
//   clk   system clock (single domain)
//   rst   asynchronous, active-low reset
//   bus   game_ctrl_if.slave -- keys, frame_tick, hit, win in;
//         start_game, left, right, jump, player_rst, lives, game_state out
// ---------------------------------------------------------------------------
module game_ctrl #(
  parameter int LIVES_INIT        = 3,
  parameter int HIT_FREEZE_FRAMES = 120,
  parameter int END_HOLD_FRAMES   = 240
) (
  input  logic       clk,
  input  logic       rst,
  game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_MENU = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [9:0] HIT_LAST   = 10'(HIT_FREEZE_FRAMES - 1);
  localparam logic [9:0] END_LAST   = 10'(END_HOLD_FRAMES - 1);
  localparam logic [9:0] CNT_MAX    = 10'h3FF;

  // Life decrement that stops at zero instead of wrapping to 3.
  function automatic logic [1:0] lives_dec_sat(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  // Frame counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [9:0] cnt_inc_sat(input logic [9:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 10'd1;
  endfunction

  state_t     state_q,      state_d;
  logic [1:0] lives_q,      lives_d;
  logic [9:0] frame_cnt_q,  frame_cnt_d;
  logic       player_rst_q, player_rst_d;
  logic       start_q;
  logic       start_rise;
  logic       hit_done;
  logic       end_done;

  // start_q resets to 1 so a key already held through reset is not an edge.
  assign start_rise = bus.key_start & ~start_q;

  // Terminal compares are qualified by the tick itself, so the count that
  // reaches LAST on one tick exits on the next tick, not immediately.
  assign hit_done = bus.frame_tick && (frame_cnt_q == HIT_LAST);
  assign end_done = bus.frame_tick && (frame_cnt_q == END_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_MENU;
      lives_q      <= 2'd0;
      frame_cnt_q  <= 10'd0;
      player_rst_q <= 1'b0;
      start_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      frame_cnt_q  <= frame_cnt_d;
      player_rst_q <= player_rst_d;
      start_q      <= bus.key_start;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    frame_cnt_d  = frame_cnt_q;
    player_rst_d = 1'b0;

    case (state_q)
      S_MENU: begin
        if (start_rise) begin
          state_d      = S_PLAY;
          lives_d      = LIVES_LOAD;
          frame_cnt_d  = 10'd0;
          player_rst_d = 1'b1;
        end
      end

      S_PLAY: begin
        // A win on the same cycle as a hit is still a win.
        if (bus.win) begin
          state_d     = S_WIN;
          frame_cnt_d = 10'd0;
        end else if (bus.hit) begin
          frame_cnt_d = 10'd0;
          if (lives_q > 2'd1) begin
            state_d = S_HIT;
            lives_d = lives_dec_sat(lives_q);
          end else begin
            state_d = S_OVER;
            lives_d = 2'd0;
          end
        end
      end

      S_HIT: begin
        if (hit_done) begin
          state_d      = S_PLAY;
          frame_cnt_d  = 10'd0;
          player_rst_d = 1'b1;
        end else if (bus.frame_tick) begin
          frame_cnt_d = cnt_inc_sat(frame_cnt_q);
        end
      end

      S_WIN, S_OVER: begin
        if (end_done) begin
          state_d     = S_MENU;
          frame_cnt_d = 10'd0;
        end else if (bus.frame_tick) begin
          frame_cnt_d = cnt_inc_sat(frame_cnt_q);
        end
      end

      default: begin
        state_d     = S_MENU;
        frame_cnt_d = 10'd0;
      end
    endcase

    // Every path into player_rst leaves PLAY-entry states, so back-to-back
    // pulses cannot happen; the guard keeps that true if the FSM grows.
    player_rst_d = player_rst_d & ~player_rst_q;
  end

  // Outputs: movement gating is combinational so it drops with the state.
  assign bus.start_game = (state_q == S_PLAY);
  assign bus.left       = (state_q == S_PLAY) & bus.key_left  & ~bus.key_right;
  assign bus.right      = (state_q == S_PLAY) & bus.key_right & ~bus.key_left;
  assign bus.jump       = (state_q == S_PLAY) & bus.key_jump;
  assign bus.player_rst = player_rst_q;
  assign bus.lives      = lives_q;
  assign bus.game_state = state_q;

endmodule
